// File: rtl/test_block_source_pkg.sv
// Shared types and default widths for the test_block_source block-read pattern source.
package test_block_source_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READY  = 2'd1,
    ACTIVE = 2'd2,
    GAP    = 2'd3
  } state_e;

  localparam int DATA_W = 32'd32;
  localparam int SIZE_W = 32'd24;
  localparam int GAP_W  = 32'd8;

endpackage

// File: rtl/test_block_source_if.sv
// Single-bank block read handshake: source (master) offers blocks, reader (slave) consumes them.
interface test_block_source_if
  import test_block_source_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int SIZE_WIDTH = SIZE_W
);

  logic                  ready;
  logic                  activate;
  logic [SIZE_WIDTH-1:0] size;
  logic                  strobe;
  logic [DATA_WIDTH-1:0] data;

  modport master (
    output ready,
    output size,
    output data,
    input  activate,
    input  strobe
  );

  modport slave (
    input  ready,
    input  size,
    input  data,
    output activate,
    output strobe
  );

endinterface

// File: rtl/test_block_source.sv
// Offers fixed-size blocks of a global incrementing word pattern on the block read handshake.
// Protocol-violation flagging is built only when TEST_BLOCK_SOURCE_ERR_CHECK_EN is defined.
module test_block_source
  import test_block_source_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int SIZE_WIDTH = SIZE_W,
  parameter int GAP_WIDTH  = GAP_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [SIZE_WIDTH-1:0] block_size,
  input  logic [GAP_WIDTH-1:0]  gap,
  test_block_source_if.master   rd,
  output logic [31:0]           blocks_done,
  output logic                  error
);

  localparam logic [DATA_WIDTH-1:0] DATA_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [SIZE_WIDTH-1:0] SIZE_ONE = {{(SIZE_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [GAP_WIDTH-1:0]  GAP_ONE  = {{(GAP_WIDTH-1){1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic                  ready_q, ready_d;
  logic [SIZE_WIDTH-1:0] size_q, size_d;
  logic [SIZE_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic [GAP_WIDTH-1:0]  gap_cnt_q, gap_cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [31:0]           blocks_done_q, blocks_done_d;
  logic                  error_q, error_d;

  // Next-state and datapath for the block offer / read / gap sequence.
  always_comb begin
    state_d       = state_q;
    ready_d       = ready_q;
    size_d        = size_q;
    word_cnt_d    = word_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    data_d        = data_q;
    blocks_done_d = blocks_done_q;
    case (state_q)
      IDLE: begin
        if (enable && (block_size != {SIZE_WIDTH{1'b0}})) begin
          size_d  = block_size;
          ready_d = 1'b1;
          state_d = READY;
        end else begin
          state_d = IDLE;
        end
      end
      READY: begin
        if (rd.activate) begin
          ready_d    = 1'b0;
          word_cnt_d = {SIZE_WIDTH{1'b0}};
          state_d    = ACTIVE;
        end else begin
          state_d = READY;
        end
      end
      ACTIVE: begin
        // A dropped activate wins over a same-cycle strobe; unread words are simply skipped.
        if (!rd.activate) begin
          blocks_done_d = blocks_done_q + 32'd1;
          gap_cnt_d     = gap;
          state_d       = GAP;
        end else if (rd.strobe && (word_cnt_q < size_q)) begin
          data_d     = data_q + DATA_ONE;
          word_cnt_d = word_cnt_q + SIZE_ONE;
        end else begin
          state_d = ACTIVE;
        end
      end
      GAP: begin
        if (gap_cnt_q == {GAP_WIDTH{1'b0}}) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b0;
      end
    endcase
  end

`ifdef TEST_BLOCK_SOURCE_ERR_CHECK_EN
  logic violation;

  // Sticky protocol-violation detection.
  always_comb begin
    violation = (rd.strobe && (state_q != ACTIVE))
             || (rd.activate && ((state_q == IDLE) || (state_q == GAP)))
             || ((state_q == ACTIVE) && rd.activate && rd.strobe && (word_cnt_q == size_q))
             || ((state_q == ACTIVE) && !rd.activate && (word_cnt_q < size_q));
    error_d = error_q | violation;
  end
`else
  // Violation flagging not built: error stays low.
  always_comb begin
    error_d = 1'b0;
  end
`endif

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ready_q       <= 1'b0;
      size_q        <= {SIZE_WIDTH{1'b0}};
      word_cnt_q    <= {SIZE_WIDTH{1'b0}};
      gap_cnt_q     <= {GAP_WIDTH{1'b0}};
      data_q        <= {DATA_WIDTH{1'b0}};
      blocks_done_q <= 32'd0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      ready_q       <= ready_d;
      size_q        <= size_d;
      word_cnt_q    <= word_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      data_q        <= data_d;
      blocks_done_q <= blocks_done_d;
      error_q       <= error_d;
    end
  end

  assign rd.ready    = ready_q;
  assign rd.size     = size_q;
  assign rd.data     = data_q;
  assign blocks_done = blocks_done_q;
  assign error       = error_q;

endmodule

// File: tb/tb_test_block_source.sv
// Directed self-checking bench for test_block_source; expected error values follow
// TEST_BLOCK_SOURCE_ERR_CHECK_EN.
module tb_test_block_source;
  import test_block_source_pkg::*;

`ifdef TEST_BLOCK_SOURCE_ERR_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [23:0] block_size;
  logic [7:0]  gap;
  logic [31:0] blocks_done;
  logic        error;
  int          n_cmp = 0;
  int          n_mis = 0;

  always #5 clk = ~clk;

  test_block_source_if #(.DATA_WIDTH(32), .SIZE_WIDTH(24)) rd_if ();

  test_block_source dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .block_size  (block_size),
    .gap         (gap),
    .rd          (rd_if.master),
    .blocks_done (blocks_done),
    .error       (error)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; enable = 1'b0; block_size = 24'd0; gap = 8'd0;
    rd_if.activate = 1'b0; rd_if.strobe = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (rd_if.ready !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; block_size = 24'd5; gap = 8'd0;
    rd_if.activate = 1'b0; rd_if.strobe = 1'b0;
    tick(); tick();
    n_cmp++; if (rd_if.ready !== 1'b0) begin n_mis++; $display("FAIL reset_ready: got %0h want 0", rd_if.ready); end
    n_cmp++; if (rd_if.size !== 24'd0) begin n_mis++; $display("FAIL reset_size: got %0h want 0", rd_if.size); end
    n_cmp++; if (rd_if.data !== 32'd0) begin n_mis++; $display("FAIL reset_data: got %0h want 0", rd_if.data); end
    n_cmp++; if (blocks_done !== 32'd0) begin n_mis++; $display("FAIL reset_blocks_done: got %0h want 0", blocks_done); end
    n_cmp++; if (error !== 1'b0) begin n_mis++; $display("FAIL reset_error: got %0h want 0", error); end
    n_cmp++; if (dut.state_q !== IDLE) begin n_mis++; $display("FAIL reset_state: got %0d want %0d", dut.state_q, IDLE); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int cyc;
    apply_reset();
    block_size = 24'd4; gap = 8'd0; enable = 1'b1;
    wait_ready(cyc);
    n_cmp++; if (rd_if.size !== 24'd4) begin n_mis++; $display("FAIL basic_size: got %0d want 4", rd_if.size); end
    rd_if.activate = 1'b1;
    tick();
    n_cmp++; if (rd_if.ready !== 1'b0) begin n_mis++; $display("FAIL basic_ready_drop: got %0h want 0", rd_if.ready); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (rd_if.data !== 32'(i)) begin n_mis++; $display("FAIL basic_data: got %0d want %0d", rd_if.data, i); end
      rd_if.strobe = 1'b1;
      tick();
    end
    rd_if.strobe = 1'b0; rd_if.activate = 1'b0;
    tick();
    n_cmp++; if (blocks_done !== 32'd1) begin n_mis++; $display("FAIL basic_blocks_done: got %0d want 1", blocks_done); end
    wait_ready(cyc);
    n_cmp++; if (cyc !== 2) begin n_mis++; $display("FAIL basic_gap_latency: got %0d want 2", cyc); end
    n_cmp++; if (rd_if.size !== 24'd4) begin n_mis++; $display("FAIL basic_size2: got %0d want 4", rd_if.size); end
    enable = 1'b0;
    tick(); tick(); tick();
    n_cmp++; if (rd_if.ready !== 1'b1) begin n_mis++; $display("FAIL basic_enable_fall_hold: got %0h want 1", rd_if.ready); end
    n_cmp++; if (error !== 1'b0) begin n_mis++; $display("FAIL basic_error: got %0h want 0", error); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    int exp_data;
    apply_reset();
    block_size = 24'd3; gap = 8'd5; enable = 1'b1;
    exp_data = 0;
    for (int blk = 0; blk < 3; blk++) begin
      wait_ready(cyc);
      n_cmp++; if (rd_if.ready !== 1'b1) begin n_mis++; $display("FAIL b2b_ready blk%0d: got %0h want 1", blk, rd_if.ready); end
      if (blk > 0) begin
        n_cmp++; if (cyc !== 7) begin n_mis++; $display("FAIL b2b_gap_latency blk%0d: got %0d want 7", blk, cyc); end
      end
      rd_if.activate = 1'b1;
      tick();
      for (int w = 0; w < 3; w++) begin
        n_cmp++; if (rd_if.data !== 32'(exp_data)) begin n_mis++; $display("FAIL b2b_data: got %0d want %0d", rd_if.data, exp_data); end
        rd_if.strobe = 1'b1;
        tick();
        exp_data++;
      end
      rd_if.strobe = 1'b0; rd_if.activate = 1'b0;
      tick();
    end
    enable = 1'b0;
    n_cmp++; if (blocks_done !== 32'd3) begin n_mis++; $display("FAIL b2b_blocks_done: got %0d want 3", blocks_done); end
    n_cmp++; if (error !== 1'b0) begin n_mis++; $display("FAIL b2b_error: got %0h want 0", error); end
  endtask

  task automatic test_zero_size();
    logic saw_ready;
    logic left_idle;
    apply_reset();
    block_size = 24'd0; enable = 1'b1;
    saw_ready = 1'b0; left_idle = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rd_if.ready !== 1'b0) saw_ready = 1'b1;
      if (dut.state_q !== IDLE) left_idle = 1'b1;
    end
    n_cmp++; if (saw_ready !== 1'b0) begin n_mis++; $display("FAIL zero_size_ready: got %0h want 0", saw_ready); end
    n_cmp++; if (left_idle !== 1'b0) begin n_mis++; $display("FAIL zero_size_state: got %0h want 0", left_idle); end
    enable = 1'b0;
  endtask

  task automatic test_overrun();
    int cyc;
    apply_reset();
    block_size = 24'd2; gap = 8'd0; enable = 1'b1;
    wait_ready(cyc);
    enable = 1'b0;
    rd_if.activate = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (rd_if.data !== 32'((i < 2) ? i : 2)) begin n_mis++; $display("FAIL overrun_data: got %0d want %0d", rd_if.data, (i < 2) ? i : 2); end
      rd_if.strobe = 1'b1;
      tick();
    end
    rd_if.strobe = 1'b0;
    n_cmp++; if (rd_if.data !== 32'd2) begin n_mis++; $display("FAIL overrun_hold: got %0d want 2", rd_if.data); end
    n_cmp++; if (error !== ERR_EN) begin n_mis++; $display("FAIL overrun_error: got %0h want %0h", error, ERR_EN); end
    rd_if.activate = 1'b0;
    tick();
  endtask

  task automatic test_short_read();
    int cyc;
    apply_reset();
    block_size = 24'd8; gap = 8'd0; enable = 1'b1;
    wait_ready(cyc);
    rd_if.activate = 1'b1;
    tick();
    rd_if.strobe = 1'b1;
    tick(); tick(); tick();
    rd_if.strobe = 1'b0;
    n_cmp++; if (rd_if.data !== 32'd3) begin n_mis++; $display("FAIL short_data: got %0d want 3", rd_if.data); end
    n_cmp++; if (error !== 1'b0) begin n_mis++; $display("FAIL short_error_early: got %0h want 0", error); end
    rd_if.activate = 1'b0;
    tick();
    n_cmp++; if (error !== ERR_EN) begin n_mis++; $display("FAIL short_error: got %0h want %0h", error, ERR_EN); end
    n_cmp++; if (blocks_done !== 32'd1) begin n_mis++; $display("FAIL short_blocks_done: got %0d want 1", blocks_done); end
    wait_ready(cyc);
    rd_if.activate = 1'b1;
    tick();
    n_cmp++; if (rd_if.data !== 32'd3) begin n_mis++; $display("FAIL short_next_first: got %0d want 3", rd_if.data); end
    n_cmp++; if (rd_if.size !== 24'd8) begin n_mis++; $display("FAIL short_next_size: got %0d want 8", rd_if.size); end
    rd_if.activate = 1'b0; enable = 1'b0;
    tick();
  endtask

  task automatic test_mid_reset();
    int cyc;
    apply_reset();
    block_size = 24'd4; gap = 8'd0; enable = 1'b1;
    wait_ready(cyc);
    rd_if.strobe = 1'b1;
    tick();
    rd_if.strobe = 1'b0;
    n_cmp++; if (error !== ERR_EN) begin n_mis++; $display("FAIL midrst_pre_error: got %0h want %0h", error, ERR_EN); end
    rd_if.activate = 1'b1;
    tick();
    rd_if.strobe = 1'b1;
    tick(); tick();
    rd_if.strobe = 1'b0;
    n_cmp++; if (rd_if.data !== 32'd2) begin n_mis++; $display("FAIL midrst_pre_data: got %0d want 2", rd_if.data); end
    rst = 1'b1;
    tick();
    rst = 1'b0; rd_if.activate = 1'b0;
    n_cmp++; if (rd_if.ready !== 1'b0) begin n_mis++; $display("FAIL midrst_ready: got %0h want 0", rd_if.ready); end
    n_cmp++; if (rd_if.data !== 32'd0) begin n_mis++; $display("FAIL midrst_data: got %0d want 0", rd_if.data); end
    n_cmp++; if (blocks_done !== 32'd0) begin n_mis++; $display("FAIL midrst_blocks_done: got %0d want 0", blocks_done); end
    n_cmp++; if (error !== 1'b0) begin n_mis++; $display("FAIL midrst_error: got %0h want 0", error); end
    n_cmp++; if (dut.state_q !== IDLE) begin n_mis++; $display("FAIL midrst_state: got %0d want %0d", dut.state_q, IDLE); end
    wait_ready(cyc);
    n_cmp++; if (cyc !== 1) begin n_mis++; $display("FAIL midrst_ready_latency: got %0d want 1", cyc); end
    rd_if.activate = 1'b1;
    tick();
    n_cmp++; if (rd_if.data !== 32'd0) begin n_mis++; $display("FAIL midrst_restart_data: got %0d want 0", rd_if.data); end
    rd_if.activate = 1'b0; enable = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_zero_size();
    test_overrun();
    test_short_read();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/test_block_source.md
Name: test_block_source

Overview:
- Simulation/bench stage directly upstream of the block-reader test consumer.
- Presents fixed-size blocks of a deterministic data pattern on the single-bank read handshake: ready/activate/size/strobe/data.
- Used to exercise readers and link-layer read paths without a real FIFO.
- Tracks completed blocks and protocol violations for scoreboarding.

Parameters:
DATA_WIDTH, 32, width of data word.
SIZE_WIDTH, 24, width of size/word counters.
GAP_WIDTH, 8, width of the inter-block idle gap.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enable  in  1  allow new blocks to be offered
block_size  in  SIZE_WIDTH  words per block; sampled when a block is offered
gap  in  GAP_WIDTH  idle cycles inserted after each block
ready  out  1  block available to reader
activate  in  1  reader owns the block
size  out  SIZE_WIDTH  word count of the offered/active block
strobe  in  1  reader consumes the current data word
data  out  DATA_WIDTH  current word; first-word-fall-through
blocks_done  out  32  completed block count; wraps
error  out  1  sticky protocol violation flag

Behaviour:
- Interface: one clock (clk); reset synchronous, active-high (rst).
- Reset values: ready=0, size=0, data=0, blocks_done=0, error=0, state=IDLE, word_cnt=0, gap_cnt=0.
- Reset mid-block returns all of the above to reset values on the next edge; the data pattern restarts at 0.
- States: IDLE, READY, ACTIVE, GAP.
- IDLE, when enable=1 and block_size!=0:
  - latch size<=block_size, ready<=1 -> READY.
  - block_size==0: stay IDLE, ready stays 0.
- READY, when activate=1: ready<=0, word_cnt<=0 -> ACTIVE.
  - enable falling in READY does not withdraw the block.
  - size is stable from ready rise until leaving ACTIVE.
- ACTIVE:
  - data is valid whenever state is ACTIVE.
  - On strobe with word_cnt<size: data<=data+1 (mod 2^DATA_WIDTH), word_cnt<=word_cnt+1.
  - On strobe with word_cnt==size (overrun): data is not advanced.
  - When activate is sampled 0: blocks_done<=blocks_done+1, gap_cnt<=gap -> GAP.
  - A strobe in the same cycle activate is sampled 0 is ignored.
- GAP: decrement gap_cnt each cycle; at 0 -> IDLE.
  - gap==0 passes through GAP in one cycle.
  - Minimum latency from activate sampled low to ready high is gap+2 cycles.
- Short read (activate drops with word_cnt<size): unread words are discarded; data is not rewound, so the next block continues the sequence.
- Data pattern: one global incrementing word counter across blocks, starting at 0.
- Strobe is only legal while activate=1 in ACTIVE.

Optional Feature:
- Macro TEST_BLOCK_SOURCE_ERR_CHECK_EN.
- Defined: error<=1 (sticky until rst) on any of:
  - strobe outside ACTIVE;
  - overrun strobe;
  - activate=1 while in IDLE or GAP;
  - short read.
- Not defined: error is held 0; violations are still handled as in Behaviour (ignored, no data advance).

Decomposition:
- Package test_block_source_pkg holds:
  - state enum (IDLE, READY, ACTIVE, GAP);
  - default width constants DATA_W=32, SIZE_W=24, GAP_W=8.
- Single module; no sub-module is natural. The gap counter and word counter are inline.

Test Plan:
- block_size=4, gap=0, enable=1, reader activates and strobes 4 times -> data 0,1,2,3 while ACTIVE; blocks_done=1; ready high again 2 cycles after activate drop with size=4; error=0.
- Back-to-back with the registered-strobe reader, block_size=3, gap=5, 3 blocks -> data 0..8 in order; blocks_done=3; each ready rise is 7 cycles after the prior activate low.
- block_size=0, enable=1 for 20 cycles -> ready never asserts; state stays IDLE.
- block_size=2, reader strobes 3 times -> data 0,1 then holds at 2; with ERR_CHECK_EN error=1, without error=0.
- block_size=8, activate after 3 strobes, then drop -> short read; next block's first word=3; error=1 if enabled.
- rst asserted for 1 cycle mid-ACTIVE (word_cnt=2) -> next cycle ready=0, data=0, blocks_done=0, error=0; the next block starts at data 0.
